// File: rtl/fm_bram_unpack_rd_if.sv
// fm_bram_unpack_rd_if: bundle between the fm_bram row reader and its environment.
//   master : the reader (drives BRAM read enables/addresses, rows, fetch_finish)
//   slave  : the environment (drives fetch_en, BRAM read data, row_ready)
// Signals: fetch_en, fm_bram_ena/enb, fm_bram_addra/addrb, fm_bram_douta/doutb,
//          row_a, row_b, row_valid, row_ready, fetch_finish.
// Build option FM_RD_TAG_EN adds row_ch (channel) and row_idx (row in channel).
interface fm_bram_unpack_rd_if #(
   parameter int unsigned DW            = 16,
   parameter int unsigned ROW_LEN       = 14,
   parameter int unsigned ROWS_PER_WORD = 5,
   parameter int unsigned AW            = 5
);
   logic                                  fetch_en;
   logic                                  fm_bram_ena;
   logic                                  fm_bram_enb;
   logic [AW-1:0]                         fm_bram_addra;
   logic [AW-1:0]                         fm_bram_addrb;
   logic [ROWS_PER_WORD*ROW_LEN*DW-1:0]   fm_bram_douta;
   logic [ROWS_PER_WORD*ROW_LEN*DW-1:0]   fm_bram_doutb;
   logic [ROW_LEN*DW-1:0]                 row_a;
   logic [ROW_LEN*DW-1:0]                 row_b;
   logic                                  row_valid;
   logic                                  row_ready;
   logic                                  fetch_finish;
`ifdef FM_RD_TAG_EN
   logic [1:0]                            row_ch;
   logic [3:0]                            row_idx;

   modport master (
      input  fetch_en, fm_bram_douta, fm_bram_doutb, row_ready,
      output fm_bram_ena, fm_bram_enb, fm_bram_addra, fm_bram_addrb,
      output row_a, row_b, row_valid, fetch_finish, row_ch, row_idx
   );
   modport slave (
      output fetch_en, fm_bram_douta, fm_bram_doutb, row_ready,
      input  fm_bram_ena, fm_bram_enb, fm_bram_addra, fm_bram_addrb,
      input  row_a, row_b, row_valid, fetch_finish, row_ch, row_idx
   );
`else
   modport master (
      input  fetch_en, fm_bram_douta, fm_bram_doutb, row_ready,
      output fm_bram_ena, fm_bram_enb, fm_bram_addra, fm_bram_addrb,
      output row_a, row_b, row_valid, fetch_finish
   );
   modport slave (
      output fetch_en, fm_bram_douta, fm_bram_doutb, row_ready,
      input  fm_bram_ena, fm_bram_enb, fm_bram_addra, fm_bram_addrb,
      input  row_a, row_b, row_valid, fetch_finish
   );
`endif
endinterface

// File: rtl/fm_bram_unpack_rd.sv
// fm_bram_unpack_rd: reads packed 5-row words from both fm_bram ports in parallel and
// streams them as single 14-value rows (A/B pair per beat) over valid/ready.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fm_bram_unpack_rd_if.master (fetch control, BRAM read ports, row stream)
// Build option: define FM_RD_TAG_EN to add row_ch/row_idx tags on the row stream.
// Slot k of a word sits at bits [(4-k)*ROW_LEN*DW +: ROW_LEN*DW]; the last word of each
// channel carries a stale slot 0 that is skipped.
module fm_bram_unpack_rd #(
   parameter int unsigned DW            = 16,
   parameter int unsigned ROW_LEN       = 14,
   parameter int unsigned ROWS_PER_WORD = 5,
   parameter int unsigned WORDS_PER_CH  = 3,
   parameter int unsigned NUM_WORDS     = 9,
   parameter int unsigned B_BASE        = 9,
   parameter int unsigned RD_LAT        = 2,
   parameter int unsigned AW            = 5
) (
   input logic                 clk,
   input logic                 rst_n,
   fm_bram_unpack_rd_if.master bus
);
   localparam int unsigned RW = ROW_LEN * DW;
   localparam int unsigned WW = ROWS_PER_WORD * RW;
   localparam int unsigned SW = $clog2(ROWS_PER_WORD);
   localparam int unsigned CW = $clog2(NUM_WORDS + 1);
   localparam int unsigned PW = (WORDS_PER_CH > 1) ? $clog2(WORDS_PER_CH) : 1;

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e            state_q;
   logic              fetch_en_q;
   logic              ena_q;
   logic              fetch_finish_q;
   logic [AW-1:0]     addra_q;
   logic [AW-1:0]     addrb_q;
   logic [CW-1:0]     rd_cnt_q;
   logic [RD_LAT-1:0] lat_q;
   logic [PW-1:0]     cap_ph_q;
   logic [PW-1:0]     pf_ph_q;
   logic [WW-1:0]     pf_a_q;
   logic [WW-1:0]     pf_b_q;
   logic              pf_valid_q;
   logic [WW-1:0]     buf_a_q;
   logic [WW-1:0]     buf_b_q;
   logic              buf_valid_q;
   logic [SW-1:0]     slot_q;
`ifdef FM_RD_TAG_EN
   logic [1:0]        cap_ch_q;
   logic [1:0]        pf_ch_q;
   logic [1:0]        row_ch_q;
   logic [3:0]        row_idx_q;
`endif

   logic start, fire, last_slot, buf_free, reload, outstanding, cap, issue, drained;

   always_comb begin
      start       = bus.fetch_en & ~fetch_en_q;
      fire        = buf_valid_q & bus.row_ready;
      last_slot   = (slot_q == SW'(ROWS_PER_WORD - 1));
      buf_free    = ~buf_valid_q | (fire & last_slot);
      reload      = buf_free & pf_valid_q;
      outstanding = ena_q | (|lat_q);
      cap         = lat_q[RD_LAT-1];
      // The read is decided one cycle ahead of ena; the prefetch slot only has to be free
      // (or emptying now), since its data cannot land before RD_LAT more cycles.
      issue       = (state_q == StRead) && (rd_cnt_q < CW'(NUM_WORDS)) && !outstanding &&
                    (!pf_valid_q || reload);
      drained     = !outstanding && !pf_valid_q && buf_free;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         // Resets high so a fetch_en level held across reset does not start a pass.
         fetch_en_q     <= 1'b1;
         ena_q          <= 1'b0;
         fetch_finish_q <= 1'b0;
         addra_q        <= '0;
         addrb_q        <= AW'(B_BASE);
         rd_cnt_q       <= '0;
         lat_q          <= '0;
         cap_ph_q       <= '0;
         pf_ph_q        <= '0;
         pf_a_q         <= '0;
         pf_b_q         <= '0;
         pf_valid_q     <= 1'b0;
         buf_a_q        <= '0;
         buf_b_q        <= '0;
         buf_valid_q    <= 1'b0;
         slot_q         <= '0;
`ifdef FM_RD_TAG_EN
         cap_ch_q       <= '0;
         pf_ch_q        <= '0;
         row_ch_q       <= '0;
         row_idx_q      <= '0;
`endif
      end else begin
         fetch_en_q <= bus.fetch_en;
         lat_q      <= (lat_q << 1) | RD_LAT'(ena_q);
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q        <= StRead;
                  addra_q        <= '0;
                  addrb_q        <= AW'(B_BASE);
                  rd_cnt_q       <= '0;
                  fetch_finish_q <= 1'b0;
                  cap_ph_q       <= '0;
                  pf_valid_q     <= 1'b0;
                  buf_valid_q    <= 1'b0;
`ifdef FM_RD_TAG_EN
                  cap_ch_q       <= '0;
`endif
               end
            end
            StRead, StDrain: begin
               if (!bus.fetch_en) begin
                  // Abort: drop buffered and in-flight data, no finish.
                  state_q     <= StIdle;
                  ena_q       <= 1'b0;
                  lat_q       <= '0;
                  pf_valid_q  <= 1'b0;
                  buf_valid_q <= 1'b0;
               end else begin
                  ena_q <= issue;
                  if (ena_q) begin
                     addra_q  <= addra_q + 1'b1;
                     addrb_q  <= addrb_q + 1'b1;
                     rd_cnt_q <= rd_cnt_q + 1'b1;
                     if (state_q == StRead && rd_cnt_q == CW'(NUM_WORDS - 1)) begin
                        state_q <= StDrain;
                     end
                  end

                  if (fire && !last_slot) begin
                     slot_q <= slot_q + 1'b1;
`ifdef FM_RD_TAG_EN
                     row_idx_q <= row_idx_q + 1'b1;
`endif
                  end

                  if (reload) begin
                     buf_a_q     <= pf_a_q;
                     buf_b_q     <= pf_b_q;
                     buf_valid_q <= 1'b1;
                     slot_q      <= (pf_ph_q == PW'(WORDS_PER_CH - 1)) ? SW'(1) : '0;
`ifdef FM_RD_TAG_EN
                     row_ch_q    <= pf_ch_q;
                     // Skip words start at slot 1, so ph*5 already lands on row 10.
                     row_idx_q   <= 4'(int'(pf_ph_q) * int'(ROWS_PER_WORD));
`endif
                  end else if (buf_free) begin
                     buf_valid_q <= 1'b0;
                  end

                  // A capture only happens into an empty prefetch register.
                  if (cap) begin
                     pf_a_q     <= bus.fm_bram_douta;
                     pf_b_q     <= bus.fm_bram_doutb;
                     pf_valid_q <= 1'b1;
                     pf_ph_q    <= cap_ph_q;
`ifdef FM_RD_TAG_EN
                     pf_ch_q    <= cap_ch_q;
`endif
                     if (cap_ph_q == PW'(WORDS_PER_CH - 1)) begin
                        cap_ph_q <= '0;
`ifdef FM_RD_TAG_EN
                        cap_ch_q <= cap_ch_q + 1'b1;
`endif
                     end else begin
                        cap_ph_q <= cap_ph_q + 1'b1;
                     end
                  end else if (reload) begin
                     pf_valid_q <= 1'b0;
                  end

                  if (state_q == StDrain && drained) begin
                     state_q        <= StDone;
                     fetch_finish_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               if (!bus.fetch_en) begin
                  state_q        <= StIdle;
                  fetch_finish_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Row select out of the word buffer by slot.
   always_comb begin
      bus.row_a = '0;
      bus.row_b = '0;
      for (int k = 0; k < int'(ROWS_PER_WORD); k++) begin
         if (slot_q == SW'(k)) begin
            bus.row_a = buf_a_q[(int'(ROWS_PER_WORD) - 1 - k) * int'(RW) +: RW];
            bus.row_b = buf_b_q[(int'(ROWS_PER_WORD) - 1 - k) * int'(RW) +: RW];
         end
      end
   end

   assign bus.fm_bram_ena   = ena_q;
   assign bus.fm_bram_enb   = ena_q;
   assign bus.fm_bram_addra = addra_q;
   assign bus.fm_bram_addrb = addrb_q;
   assign bus.row_valid     = buf_valid_q;
   assign bus.fetch_finish  = fetch_finish_q;
`ifdef FM_RD_TAG_EN
   assign bus.row_ch        = row_ch_q;
   assign bus.row_idx       = row_idx_q;
`endif

endmodule
